mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between instruction fetch (IF) and the data access of the MEM stage.
- One FSM owns the memory port and holds each granted request until mem_ready.
- Data requests have priority over fetches. A starvation counter guarantees fetch progress.
- Drives the data-busy and fetch-stall inputs of the hazard logic.

---
 rtl/mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional feature ARB_TIMEOUT_EN: access timeout with sticky bus_err.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_ready,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_ready,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  data_busy,
    output logic                  fetch_stall,
    output logic                  bus_err
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("mem_port_arbiter: DATA_W must be a multiple of 8");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_ACC  = 2'd1,
        IF_ACC = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                if_ready_q, if_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic                discard_q, discard_d;
    logic                fetch_ok;
`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]          tmo_cnt_q, tmo_cnt_d;
    logic                bus_err_q, bus_err_d;
`endif

    // A fetch only competes for the port when it is not being flushed this cycle.
    assign fetch_ok = if_req && !if_flush;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        starve_cnt_d = starve_cnt_q;
        discard_d    = discard_q;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        bus_err_d    = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_req && !(fetch_ok && starve_cnt_q == STARVE_MAX)) begin
                    state_d     = D_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_we ? d_wstrb : '0;
                    if (!if_req) begin
                        starve_cnt_d = 4'd0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
`endif
                end else if (fetch_ok) begin
                    state_d      = IF_ACC;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    mem_wstrb_d  = '0;
                    starve_cnt_d = 4'd0;
                    discard_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
`endif
                end
            end
            D_ACC: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = '0;
                    d_ready_d   = 1'b1;
                    // Stores leave the previously loaded value in place.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = '0;
                    d_ready_d   = 1'b1;
                    d_rdata_d   = '0;
                    bus_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            IF_ACC: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    discard_d   = 1'b0;
                    if (!discard_q && !if_flush) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!discard_q && !if_flush) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (if_flush) begin
                        discard_d = 1'b1;
                    end
                end
`else
                else if (if_flush) begin
                    discard_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            starve_cnt_q <= 4'd0;
            discard_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q    <= 8'd0;
            bus_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            starve_cnt_q <= starve_cnt_d;
            discard_q    <= discard_d;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            bus_err_q    <= bus_err_d;
`endif
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign if_ready    = if_ready_q;
    assign if_rdata    = if_rdata_q;
    assign d_ready     = d_ready_q;
    assign d_rdata     = d_rdata_q;
    assign data_busy   = d_req && !d_ready_q;
    assign fetch_stall = if_req && !if_ready_q && !if_flush;
`ifdef ARB_TIMEOUT_EN
    assign bus_err     = bus_err_q;
`else
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of the arbitration and starvation rules.
module tb_mem_port_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int LIMIT = 4;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0, if_flush = 1'b0, if_ready;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0, d_we = 1'b0, d_ready;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0, d_rdata;
    logic [SW-1:0] d_wstrb = '0;
    logic          mem_req, mem_we, mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata = '0;
    logic [SW-1:0] mem_wstrb;
    logic          data_busy, fetch_stall, bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .data_busy(data_busy), .fetch_stall(fetch_stall), .bus_err(bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_flush = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) step();
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== '0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (mem_wstrb !== '0) $display("FAIL reset_mem_wstrb: got %b want 0", mem_wstrb); else n_pass++;
        n_checks++; if (if_ready !== 1'b0 || d_ready !== 1'b0) $display("FAIL reset_ready: got if=%b d=%b want 0", if_ready, d_ready); else n_pass++;
        n_checks++; if (if_rdata !== '0 || d_rdata !== '0) $display("FAIL reset_rdata: got if=%h d=%h want 0", if_rdata, d_rdata); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else n_pass++;
        $display("reset: outputs sampled while rst_n low");
        rst_n = 1;
        clear_inputs();
        step();
    endtask

    task automatic test_single_load();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h100; d_wstrb = 4'hF;
        #1;
        n_checks++; if (data_busy !== 1'b1) $display("FAIL load_busy_pre: got %b want 1", data_busy); else n_pass++;
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) $display("FAIL load_grant: got req=%b addr=%h want 1/100", mem_req, mem_addr); else n_pass++;
        n_checks++; if (mem_we !== 1'b0 || mem_wstrb !== '0) $display("FAIL load_we_strb: got we=%b strb=%b want 0/0", mem_we, mem_wstrb); else n_pass++;
        step(); step();
        n_checks++; if (mem_req !== 1'b1 || d_ready !== 1'b0 || data_busy !== 1'b1) $display("FAIL load_hold: got req=%b rdy=%b busy=%b want 1/0/1", mem_req, d_ready, data_busy); else n_pass++;
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        n_checks++; if (d_ready !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) $display("FAIL load_done: got rdy=%b data=%h want 1/deadbeef", d_ready, d_rdata); else n_pass++;
        n_checks++; if (mem_req !== 1'b0 || data_busy !== 1'b0) $display("FAIL load_release: got req=%b busy=%b want 0/0", mem_req, data_busy); else n_pass++;
        d_req = 0; mem_ready = 0; mem_rdata = '0;
        step();
        n_checks++; if (d_ready !== 1'b0 || mem_req !== 1'b0) $display("FAIL load_pulse_len: got rdy=%b req=%b want 0/0", d_ready, mem_req); else n_pass++;
        $display("txn load addr=00000100 rdata=%h", d_rdata);
    endtask

    task automatic test_store_strobes();
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'h1122_3344; d_wstrb = 4'b0011;
        step();
        n_checks++; if (mem_we !== 1'b1 || mem_wstrb !== 4'b0011) $display("FAIL store_we_strb: got we=%b strb=%b want 1/0011", mem_we, mem_wstrb); else n_pass++;
        n_checks++; if (mem_wdata !== 32'h1122_3344 || mem_addr !== 32'h204) $display("FAIL store_data: got %h@%h want 11223344@204", mem_wdata, mem_addr); else n_pass++;
        mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
        step();
        n_checks++; if (d_ready !== 1'b1 || d_rdata !== 32'h0) $display("FAIL store_done: got rdy=%b data=%h want 1/0", d_ready, d_rdata); else n_pass++;
        d_req = 0; mem_ready = 0;
        step();
        $display("txn store addr=00000204 wdata=11223344 strb=0011");
    endtask

    task automatic test_flush_in_flight();
        do_reset();
        if_req = 1; if_addr = 32'h40;
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_wstrb !== '0) $display("FAIL flush_grant: got req=%b addr=%h we=%b strb=%b want 1/40/0/0", mem_req, mem_addr, mem_we, mem_wstrb); else n_pass++;
        n_checks++; if (fetch_stall !== 1'b1) $display("FAIL flush_stall_pre: got %b want 1", fetch_stall); else n_pass++;
        if_flush = 1; if_req = 0;
        #1;
        n_checks++; if (fetch_stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", fetch_stall); else n_pass++;
        step();
        if_flush = 0; if_req = 1; if_addr = 32'h80;
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        n_checks++; if (mem_addr !== 32'h40) $display("FAIL flush_addr_stable: got %h want 40", mem_addr); else n_pass++;
        step();
        n_checks++; if (if_ready !== 1'b0 || if_rdata !== '0 || mem_req !== 1'b0) $display("FAIL flush_discard: got rdy=%b data=%h req=%b want 0/0/0", if_ready, if_rdata, mem_req); else n_pass++;
        mem_ready = 0;
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) $display("FAIL flush_regrant: got req=%b addr=%h want 1/80", mem_req, mem_addr); else n_pass++;
        mem_ready = 1; mem_rdata = 32'h0BAD_C0DE;
        step();
        n_checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h0BAD_C0DE) $display("FAIL flush_next_fetch: got rdy=%b data=%h want 1/0badc0de", if_ready, if_rdata); else n_pass++;
        $display("txn fetch addr=00000080 rdata=%h (after discarded fetch at 00000040)", if_rdata);
        if_req = 0; mem_ready = 0;
        step();
        if_req = 1; if_flush = 1; if_addr = 32'hC0;
        step();
        n_checks++; if (mem_req !== 1'b0) $display("FAIL flush_idle_block: got req=%b want 0", mem_req); else n_pass++;
        if_flush = 0;
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hC0) $display("FAIL flush_idle_after: got req=%b addr=%h want 1/c0", mem_req, mem_addr); else n_pass++;
        mem_ready = 1;
        step();
        if_req = 0; mem_ready = 0;
        step();
    endtask

    task automatic test_starvation();
        logic prev_req = 1'b0;
        int   n_grant = 0;
        int   k_if = 2 * LIMIT + 2;
        bit   want_fetch, got_fetch;
        do_reset();
        d_req = 1; d_addr = 32'h2000; if_req = 1; if_addr = 32'h1000;
        mem_ready = 1; mem_rdata = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (mem_req && !prev_req) begin
                // Every (LIMIT+1)-th grant goes to the waiting fetch.
                want_fetch = ((n_grant + 1) % (LIMIT + 1)) == 0;
                got_fetch  = (mem_addr == 32'h1000);
                n_checks++; if (got_fetch !== want_fetch) $display("FAIL starve_order[%0d]: got fetch=%b want fetch=%b", n_grant, got_fetch, want_fetch); else n_pass++;
                $display("txn grant %0d -> %s", n_grant, got_fetch ? "IF" : "D");
                n_grant++;
            end
            prev_req = mem_req;
            if (k < k_if) begin
                n_checks++; if (fetch_stall !== 1'b1) $display("FAIL starve_stall[%0d]: got %b want 1", k, fetch_stall); else n_pass++;
            end else if (k == k_if) begin
                n_checks++; if (if_ready !== 1'b1 || fetch_stall !== 1'b0) $display("FAIL starve_if_ready: got rdy=%b stall=%b want 1/0", if_ready, fetch_stall); else n_pass++;
            end
        end
        n_checks++; if (n_grant != 10) $display("FAIL starve_grant_count: got %0d want 10", n_grant); else n_pass++;
        clear_inputs();
        step(); step();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h300;
        step();
        n_checks++; if (mem_req !== 1'b1) $display("FAIL rst_mid_grant: got %b want 1", mem_req); else n_pass++;
        #2 rst_n = 0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mid_async: got req=%b want 0", mem_req); else n_pass++;
        d_req = 0; mem_ready = 1;
        step();
        n_checks++; if (d_ready !== 1'b0 || mem_req !== 1'b0) $display("FAIL rst_mid_held: got rdy=%b req=%b want 0/0", d_ready, mem_req); else n_pass++;
        rst_n = 1; mem_ready = 0;
        step();
        n_checks++; if (d_ready !== 1'b0 || mem_req !== 1'b0) $display("FAIL rst_mid_idle: got rdy=%b req=%b want 0/0", d_ready, mem_req); else n_pass++;
        $display("txn reset during data access at 00000300");
    endtask

    task automatic test_timeout();
        do_reset();
`ifdef ARB_TIMEOUT_EN
        d_req = 1; d_addr = 32'h400;
        step();
        mem_ready = 1; mem_rdata = 32'h7777_7777;
        step();
        d_req = 0; mem_ready = 0;
        step();
        d_req = 1; d_addr = 32'h404;
        step();
        repeat (TMO - 1) step();
        n_checks++; if (d_ready !== 1'b0 || mem_req !== 1'b1 || bus_err !== 1'b0) $display("FAIL tmo_early: got rdy=%b req=%b err=%b want 0/1/0", d_ready, mem_req, bus_err); else n_pass++;
        step();
        n_checks++; if (d_ready !== 1'b1 || d_rdata !== '0 || mem_req !== 1'b0) $display("FAIL tmo_abort: got rdy=%b data=%h req=%b want 1/0/0", d_ready, d_rdata, mem_req); else n_pass++;
        n_checks++; if (bus_err !== 1'b1) $display("FAIL tmo_bus_err: got %b want 1", bus_err); else n_pass++;
        d_req = 0;
        step();
        d_req = 1; d_addr = 32'h408;
        step();
        mem_ready = 1; mem_rdata = 32'h5555_5555;
        step();
        n_checks++; if (d_ready !== 1'b1 || d_rdata !== 32'h5555_5555 || bus_err !== 1'b1) $display("FAIL tmo_sticky: got rdy=%b data=%h err=%b want 1/55555555/1", d_ready, d_rdata, bus_err); else n_pass++;
        $display("txn timeout abort then good load, bus_err=%b", bus_err);
`else
        d_req = 1; d_addr = 32'h400;
        step();
        repeat (TMO + 4) step();
        n_checks++; if (mem_req !== 1'b1 || d_ready !== 1'b0 || bus_err !== 1'b0) $display("FAIL no_tmo_wait: got req=%b rdy=%b err=%b want 1/0/0", mem_req, d_ready, bus_err); else n_pass++;
        mem_ready = 1; mem_rdata = 32'h5555_5555;
        step();
        n_checks++; if (d_ready !== 1'b1 || d_rdata !== 32'h5555_5555) $display("FAIL no_tmo_done: got rdy=%b data=%h want 1/55555555", d_ready, d_rdata); else n_pass++;
        $display("txn long-latency load completed, no timeout");
`endif
        clear_inputs();
        step();
    endtask

    // Randomized traffic: the bench acts as both requesters and the memory.
    task automatic test_random_traffic();
        int          owner = 0;      // 0 none, 1 data, 2 fetch
        int          waits = 0, age = 0;
        bit          discard = 0, fp = 0;
        logic        e_req = 0, e_we = 0, e_d_rdy = 0, e_if_rdy = 0;
        logic [AW-1:0] e_addr = '0;
        logic [DW-1:0] e_wdata = '0, e_d_rdata = '0, e_if_rdata = '0;
        logic [SW-1:0] e_strb = '0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks++; if (mem_req !== e_req) $display("FAIL rnd_mem_req@%0d: got %b want %b", cyc, mem_req, e_req); else n_pass++;
            if (e_req) begin
                n_checks++; if (mem_addr !== e_addr || mem_we !== e_we || mem_wstrb !== e_strb) $display("FAIL rnd_access@%0d: got %h/%b/%b want %h/%b/%b", cyc, mem_addr, mem_we, mem_wstrb, e_addr, e_we, e_strb); else n_pass++;
                if (e_we) begin
                    n_checks++; if (mem_wdata !== e_wdata) $display("FAIL rnd_wdata@%0d: got %h want %h", cyc, mem_wdata, e_wdata); else n_pass++;
                end
            end
            n_checks++; if (d_ready !== e_d_rdy || d_rdata !== e_d_rdata) $display("FAIL rnd_data@%0d: got %b/%h want %b/%h", cyc, d_ready, d_rdata, e_d_rdy, e_d_rdata); else n_pass++;
            n_checks++; if (if_ready !== e_if_rdy || if_rdata !== e_if_rdata) $display("FAIL rnd_fetch@%0d: got %b/%h want %b/%h", cyc, if_ready, if_rdata, e_if_rdy, e_if_rdata); else n_pass++;

            if_flush = 0;
            if (e_d_rdy) d_req = 0;
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1; d_we = $urandom_range(0, 1) == 1;
                d_addr = 32'h2000_0000 | ($urandom & 32'hFFFC);
                d_wdata = $urandom; d_wstrb = SW'($urandom);
            end
            if (e_if_rdy) if_req = 0;
            if (if_req && $urandom_range(0, 9) == 0) begin
                if_flush = 1; if_req = 0;
            end else if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req = 1; if_addr = 32'h1000_0000 | ($urandom & 32'hFFFC);
            end
            mem_rdata = $urandom;
            mem_ready = (owner != 0 && age >= 3) || ($urandom_range(0, 1) == 1);
            #1;
            n_checks++; if (data_busy !== (d_req && !e_d_rdy)) $display("FAIL rnd_data_busy@%0d: got %b want %b", cyc, data_busy, d_req && !e_d_rdy); else n_pass++;
            n_checks++; if (fetch_stall !== (if_req && !e_if_rdy && !if_flush)) $display("FAIL rnd_fetch_stall@%0d: got %b want %b", cyc, fetch_stall, if_req && !e_if_rdy && !if_flush); else n_pass++;

            e_d_rdy = 0; e_if_rdy = 0;
            if (owner == 0) begin
                fp = if_req && !if_flush;
                if (d_req && !(fp && waits == LIMIT)) begin
                    owner = 1; e_req = 1; e_addr = d_addr; e_we = d_we;
                    e_wdata = d_wdata; e_strb = d_we ? d_wstrb : '0; age = 0;
                    waits = if_req ? ((waits < LIMIT) ? waits + 1 : waits) : 0;
                end else if (fp) begin
                    owner = 2; e_req = 1; e_addr = if_addr; e_we = 0;
                    e_strb = '0; waits = 0; discard = 0; age = 0;
                end
            end else if (mem_ready) begin
                if (owner == 1) begin
                    e_d_rdy = 1;
                    if (!e_we) e_d_rdata = mem_rdata;
                    $display("txn data %s addr=%h data=%h", e_we ? "store" : "load", e_addr, e_we ? e_wdata : mem_rdata);
                end else if (!discard && !if_flush) begin
                    e_if_rdy = 1; e_if_rdata = mem_rdata;
                    $display("txn fetch addr=%h data=%h", e_addr, mem_rdata);
                end else begin
                    $display("txn fetch addr=%h discarded", e_addr);
                end
                owner = 0; e_req = 0; e_we = 0; e_strb = '0; discard = 0;
            end else begin
                age++;
                if (owner == 2 && if_flush) discard = 1;
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store_strobes();
        test_flush_in_flight();
        test_starvation();
        test_reset_mid_access();
        test_timeout();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
